// File: rtl/effect_sequencer.sv
// ============================================================================
// effect_sequencer - four-slot light / sound / movement effect sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

module effect_sequencer #(
  parameter int DWELL_W     = 8,
  parameter int SND_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               loop,
  input  logic               prog_we,
  input  logic [1:0]         prog_addr,
  input  logic [3:0]         prog_data,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               snd_done,
  output logic               busy,
  output logic [1:0]         slot,
  output logic [1:0]         color,
  output logic               color_valid,
  output logic               snd_req,
  output logic [1:0]         snd_code,
  output logic [2:0]         move_en,
  output logic               err
);

  localparam int TO_W = $clog2(SND_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    DWELL    = 2'd2,
    SND_WAIT = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [3:0]         prog [4];
  logic [DWELL_W-1:0] dwell_cnt;
  logic [TO_W-1:0]    to_cnt;
  logic [3:0]         op;
  logic               dwell_last;
  logic               to_last;
  logic               abort;

  assign op         = prog[slot];
  assign dwell_last = (dwell_cnt == '0);
  assign to_last    = (to_cnt == TO_W'(SND_TIMEOUT - 1));
  assign abort      = (state != IDLE) && stop;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start && !stop) state_nxt = FETCH;
      FETCH: begin
        case (op)
          4'b0001:                   state_nxt = IDLE;
          4'b1000, 4'b1001, 4'b1010: state_nxt = SND_WAIT;
          default:                   state_nxt = DWELL;
        endcase
      end
      SND_WAIT: if (snd_done || to_last) state_nxt = DWELL;
      DWELL: begin
        if (dwell_last) state_nxt = (slot == 2'd3 && !loop) ? IDLE : FETCH;
      end
      default:  state_nxt = IDLE;
    endcase
    // stop overrides every transition out of a running state
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) prog[i] <= '0;
      slot        <= '0;
      color       <= '0;
      color_valid <= 1'b0;
      snd_req     <= 1'b0;
      snd_code    <= '0;
      move_en     <= '0;
      err         <= 1'b0;
      dwell_cnt   <= '0;
      to_cnt      <= '0;
    end else begin
      if (abort) begin
        snd_req <= 1'b0;
        move_en <= '0;
      end else begin
        case (state)
          IDLE: if (start && !stop) slot <= '0;
          FETCH: begin
            dwell_cnt <= dwell;
            case (op)
              4'b0000: ;
              4'b0001: begin
                color_valid <= 1'b0;
                move_en     <= '0;
                slot        <= '0;
              end
              4'b0100, 4'b0101, 4'b0110: begin
                color       <= op[1:0];
                color_valid <= 1'b1;
              end
              4'b1000, 4'b1001, 4'b1010: begin
                snd_code <= op[1:0];
                snd_req  <= 1'b1;
                to_cnt   <= '0;
              end
              4'b1100, 4'b1101, 4'b1110: move_en <= 3'b001 << op[1:0];
              default: err <= 1'b1;
            endcase
          end
          SND_WAIT: begin
            if (snd_done) begin
              snd_req <= 1'b0;
            end else if (to_last) begin
              snd_req <= 1'b0;
              err     <= 1'b1;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end
          DWELL: begin
            if (dwell_last) begin
              move_en <= '0;
              slot    <= slot + 2'd1;
            end else begin
              dwell_cnt <= dwell_cnt - DWELL_W'(1);
            end
          end
          default: ;
        endcase
      end

      if (prog_we) begin
        if (state == IDLE) prog[prog_addr] <= prog_data;
        else               err             <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
